btn_repeat: RTL

BTN_REPEAT -- requirements
Module: btn_repeat

---
 rtl/jcs_io_pkg.sv | 18 +
 rtl/jsync2.sv | 25 ++
 rtl/btn_repeat.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/jcs_io_pkg.sv
// Shared definitions for the push-button / switch input blocks.
//   btn_state_e          : auto-repeat FSM state encoding (2 bits)
//   DEF_DEBOUNCE_CYCLES  : default debounce window (10 ms at 100 MHz)
//   DEF_REPEAT_DELAY     : default hold time before the first repeat
//   DEF_REPEAT_RATE      : default period between repeats
package jcs_io_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } btn_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_REPEAT_DELAY    = 50000000;
   localparam int DEF_REPEAT_RATE     = 15000000;

endpackage

// File: rtl/jsync2.sv
// Two-flop synchronizer for a single asynchronous level input.
//   CLK    : destination clock
//   RESETN : asynchronous active-low reset, clears both flops
//   d      : asynchronous input level
//   q      : synchronized level, two CLK edges behind d
module jsync2 (
   input  logic CLK,
   input  logic RESETN,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/btn_repeat.sv
// Debounced push-button with press pulse and optional auto-repeat.
//   CLK    : sole clock, all state on the rising edge
//   RESETN : asynchronous active-low reset
//   BTN    : raw, bouncing, asynchronous button level
//   CLICK  : single-cycle pulse per accepted press and per repeat tick
//   HELD   : debounced button level
module btn_repeat
   import jcs_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int REPEAT_EN       = 1
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic BTN,
   output logic CLICK,
   output logic HELD
);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("btn_repeat: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX) + 1;

   localparam logic [DW-1:0] DB_LIM   = DW'(DEBOUNCE_CYCLES);
   localparam logic [RW-1:0] DLY_LIM  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LIM = RW'(REPEAT_RATE - 1);

   logic          btn_sync;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          held_q, held_d;
   btn_state_e    state_q, state_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          click_q, click_d;
   logic          lim_hit;

   jsync2 u_sync (
      .CLK    (CLK),
      .RESETN (RESETN),
      .d      (BTN),
      .q      (btn_sync)
   );

   // Debounce: count while the synchronized level disagrees with HELD;
   // once the count has reached the window, flip HELD and restart.
   always_comb begin
      dcnt_d = dcnt_q;
      held_d = held_q;
      if (btn_sync == held_q) begin
         dcnt_d = '0;
      end else if (dcnt_q == DB_LIM) begin
         held_d = ~held_q;
         dcnt_d = '0;
      end else if (~&dcnt_q) begin
         dcnt_d = dcnt_q + DW'(1);
      end
   end

   always_comb begin
      lim_hit = 1'b0;
      case (state_q)
         ST_DELAY:  lim_hit = (REPEAT_EN != 0) && (rcnt_q == DLY_LIM);
         ST_REPEAT: lim_hit = (rcnt_q == RATE_LIM);
         default:   lim_hit = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= ST_IDLE;
         rcnt_q  <= '0;
         click_q <= 1'b0;
         dcnt_q  <= '0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         click_q <= click_d;
         dcnt_q  <= dcnt_d;
         held_q  <= held_d;
      end
   end

   // A tick that lands right after a CLICK is held off one cycle (counter
   // parked at its limit) so CLICK is never high on consecutive cycles.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      if (!held_q) begin
         state_d = ST_IDLE;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_DELAY;
               rcnt_d  = '0;
            end
            ST_DELAY: begin
               if (lim_hit) begin
                  if (!click_q) begin
                     state_d = ST_REPEAT;
                     rcnt_d  = '0;
                  end
               end else if (REPEAT_EN != 0 && ~&rcnt_q) begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            ST_REPEAT: begin
               if (lim_hit) begin
                  if (!click_q) rcnt_d = '0;
               end else if (~&rcnt_q) begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               rcnt_d  = '0;
            end
         endcase
      end
   end

   // held_d gates out a tick that would coincide with HELD falling.
   always_comb begin
      click_d = 1'b0;
      if (held_q && held_d && !click_q) begin
         case (state_q)
            ST_IDLE:   click_d = 1'b1;
            ST_DELAY,
            ST_REPEAT: click_d = lim_hit;
            default:   click_d = 1'b0;
         endcase
      end
   end

   assign CLICK = click_q;
   assign HELD  = held_q;

endmodule
